uart_tx_engine: RTL and testbench

UART transmit stage fed by the APB register slave. It takes the transmit data byte and baud divisor from the slave's register outputs. Bytes are queued in a small FIFO and serialised onto the `tx` line as 8N1 frames. Its `tf_txrdy` output drives the slave's `tf_TXRDY` status input.

---
 rtl/uart_tx_engine_if.sv | 23 ++
 rtl/uart_tx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// Register-side bundle for the UART transmit engine: divisor, data/strobe in,
// serial line and status flags out.
interface uart_tx_engine_if #(
  parameter int BITWIDTH = 8
);
  logic [BITWIDTH-1:0] i_baud_val;
  logic [BITWIDTH-1:0] tx_data;
  logic                tx_wr;
  logic                tx;
  logic                tf_txrdy;
  logic                tx_busy;
  logic                tx_ovr;

  modport master (
    output i_baud_val, tx_data, tx_wr,
    input  tx, tf_txrdy, tx_busy, tx_ovr
  );

  modport slave (
    input  i_baud_val, tx_data, tx_wr,
    output tx, tf_txrdy, tx_busy, tx_ovr
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter: small circular FIFO feeding a start/data/stop serialiser
// whose bit period is OVERSAMPLE * (divisor + 1) pclk cycles.
module uart_tx_engine #(
  parameter int BITWIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  uart_tx_engine_if.slave     bus
);
  // state   | meaning
  // S_IDLE  | line high, waiting for a queued byte
  // S_START | start bit (0) for one bit period
  // S_DATA  | BITWIDTH data bits, LSB first
  // S_STOP  | stop bit (1); chains straight into S_START if more data queued

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(OVERSAMPLE * (2 ** BITWIDTH));
  localparam int BIW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [BITWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_ovr;
  logic                r_tx;
  logic [BITWIDTH-1:0] r_shift;
  logic [BITWIDTH-1:0] r_div;
  logic [TW-1:0]       r_timer;
  logic [BIW-1:0]      r_bitidx;

  logic                w_full;
  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_bit_end;
  logic [TW-1:0]       w_pm1;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.tx_wr && !w_full;

  // P-1 = OVERSAMPLE*div + OVERSAMPLE-1, which never exceeds OVERSAMPLE*2^BITWIDTH-1
  assign w_pm1     = TW'(OVERSAMPLE) * TW'(r_div) + TW'(OVERSAMPLE - 1);
  assign w_bit_end = (r_timer == w_pm1);
  assign w_pop     = w_nonempty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));

  assign bus.tx       = r_tx;
  assign bus.tf_txrdy = !w_full;
  assign bus.tx_busy  = (r_state != S_IDLE);
  assign bus.tx_ovr   = r_ovr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.tx_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (bus.tx_wr && w_full) r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_div    <= '0;
      r_timer  <= '0;
      r_bitidx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx     <= 1'b1;
          r_timer  <= '0;
          r_bitidx <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_div   <= bus.i_baud_val;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_shift <= {1'b0, r_shift[BITWIDTH-1:1]};
            if (r_bitidx == BIW'(BITWIDTH - 1)) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bitidx <= r_bitidx + BIW'(1);
              r_tx     <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_timer  <= '0;
            r_bitidx <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_div   <= bus.i_baud_val;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a line monitor decodes every frame cycle by cycle
// against a queue of expected bytes; directed vectors plus corner sequences.
module tb_uart_tx_engine;
  logic pclk;
  logic presetn;

  uart_tx_engine_if #(.BITWIDTH(8)) bus();

  uart_tx_engine #(.BITWIDTH(8), .FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;
  int mon_p = 16;
  int busy_cnt = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] baud;
    logic [7:0] data;
    int         exp_busy;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (bus.tx_busy === 1'b1) busy_cnt++;
    if (bus.tx_busy === 1'b1 && busy_prev == 1'b0) busy_rises++;
    busy_prev = (bus.tx_busy === 1'b1);
  end

  // Line monitor: on a start bit, checks every cycle of the 10-bit frame
  initial begin
    int         p;
    int         errs;
    bit         ab;
    logic [7:0] expb;
    logic [7:0] got;
    logic [9:0] fr;
    forever begin
      @(negedge pclk);
      if (presetn === 1'b1 && bus.tx === 1'b0) begin
        p = mon_p; errs = 0; ab = 0; got = '0;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL frame_expected: unexpected start bit, queue empty at %0t", $time);
          expb = '0;
        end else begin
          expb = exp_q.pop_front();
        end
        fr = {1'b1, expb, 1'b0};
        for (int i = 0; i < 10 * p; i++) begin
          if (i > 0) @(negedge pclk);
          if (presetn !== 1'b1) begin ab = 1; break; end
          if (bus.tx !== fr[i / p]) errs++;
          if ((i % p) == (p / 2) && (i / p) >= 1 && (i / p) <= 8) got[(i / p) - 1] = bus.tx;
        end
        if (!ab) begin
          check("frame_byte", got, expb);
          check("frame_timing_errs", errs, 0);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge pclk);
    while (bus.tx_busy === 1'b1 && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("idle_reached", bus.tx_busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wr(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_wr   = 1'b1;
    @(negedge pclk);
    bus.tx_wr   = 1'b0;
  endtask

  initial begin
    int b0;
    int r0;
    vecs[0] = '{baud: 8'h00, data: 8'hA5, exp_busy: 160};
    vecs[1] = '{baud: 8'h03, data: 8'h01, exp_busy: 640};
    vecs[2] = '{baud: 8'h00, data: 8'h00, exp_busy: 160};
    vecs[3] = '{baud: 8'h01, data: 8'hFF, exp_busy: 320};
    vecs[4] = '{baud: 8'hFF, data: 8'h80, exp_busy: 40960};

    presetn = 1'b0;
    bus.tx_wr = 1'b0;
    bus.tx_data = '0;
    bus.i_baud_val = '0;
    repeat (3) @(negedge pclk);
    check("rst_tx", bus.tx, 1);
    check("rst_txrdy", bus.tf_txrdy, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_ovr", bus.tx_ovr, 0);
    presetn = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 5; i++) begin
      bus.i_baud_val = vecs[i].baud;
      mon_p = 16 * (int'(vecs[i].baud) + 1);
      b0 = busy_cnt; r0 = busy_rises;
      exp_q.push_back(vecs[i].data);
      wr(vecs[i].data);
      check("lat_busy_k", bus.tx_busy, 0);
      check("lat_tx_k", bus.tx, 1);
      @(negedge pclk);
      check("lat_busy_k1", bus.tx_busy, 1);
      check("lat_tx_k1", bus.tx, 0);
      wait_idle(vecs[i].exp_busy + 100);
      check("vec_busy_cycles", busy_cnt - b0, vecs[i].exp_busy);
      check("vec_busy_rises", busy_rises - r0, 1);
    end

    // Divisor change mid-frame only affects the following frame
    bus.i_baud_val = 8'd3; mon_p = 64;
    b0 = busy_cnt;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    wr(8'h01); wr(8'h02);
    repeat (100) @(negedge pclk);
    bus.i_baud_val = 8'd0; mon_p = 16;
    wait_idle(1000);
    check("div_busy_cycles", busy_cnt - b0, 800);

    // Back-to-back frames with no idle gap
    b0 = busy_cnt; r0 = busy_rises;
    exp_q.push_back(8'h55); exp_q.push_back(8'h0F); exp_q.push_back(8'hF0);
    wr(8'h55); wr(8'h0F); wr(8'hF0);
    wait_idle(600);
    check("b2b_busy_cycles", busy_cnt - b0, 480);
    check("b2b_busy_rises", busy_rises - r0, 1);

    // Fill the FIFO and overrun it
    b0 = busy_cnt;
    for (int k = 0; k < 5; k++) exp_q.push_back(8'h10 + 8'(k));
    for (int k = 0; k < 4; k++) wr(8'h10 + 8'(k));
    check("full_txrdy_before", bus.tf_txrdy, 1);
    check("full_ovr_before", bus.tx_ovr, 0);
    wr(8'h14);
    check("full_txrdy_after5", bus.tf_txrdy, 0);
    check("full_ovr_after5", bus.tx_ovr, 0);
    wr(8'h15);
    check("ovr_set", bus.tx_ovr, 1);
    check("ovr_txrdy", bus.tf_txrdy, 0);
    wait_idle(1000);
    check("full_busy_cycles", busy_cnt - b0, 800);
    check("ovr_sticky", bus.tx_ovr, 1);
    check("txrdy_recovered", bus.tf_txrdy, 1);

    // Reset in the middle of a frame
    exp_q.push_back(8'hAA);
    wr(8'hAA);
    wr(8'hBB);
    repeat (40) @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("midrst_tx", bus.tx, 1);
    check("midrst_busy", bus.tx_busy, 0);
    check("midrst_txrdy", bus.tf_txrdy, 1);
    check("midrst_ovr", bus.tx_ovr, 0);
    exp_q.delete();
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (200) @(negedge pclk);
    check("midrst_discarded", bus.tx_busy, 0);

    // Recovery frame after reset
    b0 = busy_cnt;
    exp_q.push_back(8'h3C);
    wr(8'h3C);
    wait_idle(300);
    check("post_rst_busy", busy_cnt - b0, 160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
